// File: rtl/tick_bcd_counter_pkg.sv
// Shared definitions for the tick-driven BCD counter.
//   state_t       : run/stop control states
//   RATE_*        : rate_sel encodings for the tick source
//   BCD_MAX/MIN   : digit bounds
//   sat_digit()   : clamps a nibble to a legal BCD digit
package tick_bcd_counter_pkg;

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] RATE_DIV1 = 2'd0;
    localparam logic [1:0] RATE_DIV2 = 2'd1;
    localparam logic [1:0] RATE_DIV3 = 2'd2;
    localparam logic [1:0] RATE_CLK  = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/tick_bcd_counter_digit.sv
// Combinational next-value unit for one BCD digit.
//   digit      : current digit value (0..9)
//   inc / dec  : increment / decrement request from the lower digit
//   next       : digit value after the step
//   carry_out  : this digit wrapped 9->0 on an increment
//   borrow_out : this digit wrapped 0->9 on a decrement
module bcd_digit
    import tick_bcd_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] next,
    output logic       carry_out,
    output logic       borrow_out
);

    always_comb begin
        next       = digit;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (inc) begin
            // >= also folds any illegal nibble back to 0
            if (digit >= BCD_MAX) begin
                next      = BCD_MIN;
                carry_out = 1'b1;
            end else begin
                next = digit + 4'd1;
            end
        end else if (dec) begin
            if (digit == BCD_MIN) begin
                next       = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of a selected
// divided clock (or every cycle), with run/stop control, load and clear.
//
// state   | meaning
// --------+------------------------------------------
// ST_STOP | ticks discarded, count holds
// ST_RUN  | each raw tick applies one count step
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   div_clk    : divided clocks (level, clk domain), bit0=clk1..bit2=clk3
//   rate_sel   : tick source select, 3 = every cycle
//   start/stop : run control pulses, stop wins when both set
//   up_dn      : 1 = up, 0 = down
//   load       : load load_val (digits saturated to 9)
//   load_val   : BCD load value
//   clear      : clear count to 0
//   count      : BCD count, digit 0 in [3:0]
//   carry      : one-cycle wrap pulse
//   tick       : one-cycle pulse per applied step
//   running    : high in ST_RUN
module tick_bcd_counter
    import tick_bcd_counter_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    localparam int CW         = 4 * NUM_DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    div_clk,
    input  logic [1:0]    rate_sel,
    input  logic          start,
    input  logic          stop,
    input  logic          up_dn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          carry,
    output logic          tick,
    output logic          running
);

    state_t          state, state_nxt;
    logic            src, src_q;
    logic [1:0]      rate_sel_q;
    logic            sel_change;
    logic            raw_tick;
    logic            step;
    logic            wrap;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   load_sat;
    logic [NUM_DIGITS:0] inc_c;
    logic [NUM_DIGITS:0] dec_c;

    always_comb begin
        case (rate_sel)
            RATE_DIV1: src = div_clk[0];
            RATE_DIV2: src = div_clk[1];
            RATE_DIV3: src = div_clk[2];
            default:   src = 1'b1;
        endcase
    end

    // On a source switch src_q still holds the old source, so its edge
    // history is meaningless for one cycle; suppress the tick there.
    assign sel_change = (rate_sel != rate_sel_q);

    always_comb begin
        if (sel_change)
            raw_tick = 1'b0;
        else if (rate_sel == RATE_CLK)
            raw_tick = 1'b1;
        else
            raw_tick = src & ~src_q;
    end

    always_comb begin
        state_nxt = state;
        if (stop)
            state_nxt = ST_STOP;
        else if (start)
            state_nxt = ST_RUN;
    end

    assign step    = (state == ST_RUN) & raw_tick;
    assign running = (state == ST_RUN);

    assign inc_c[0] = step &  up_dn;
    assign dec_c[0] = step & ~up_dn;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit      (count[4*g +: 4]),
            .inc        (inc_c[g]),
            .dec        (dec_c[g]),
            .next       (count_nxt[4*g +: 4]),
            .carry_out  (inc_c[g+1]),
            .borrow_out (dec_c[g+1])
        );
    end

    assign wrap = inc_c[NUM_DIGITS] | dec_c[NUM_DIGITS];

    always_comb begin
        load_sat = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            load_sat[4*i +: 4] = sat_digit(load_val[4*i +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_STOP;
            count      <= '0;
            carry      <= 1'b0;
            tick       <= 1'b0;
            src_q      <= 1'b0;
            rate_sel_q <= RATE_DIV1;
        end else begin
            state      <= state_nxt;
            src_q      <= src;
            rate_sel_q <= rate_sel;
            carry      <= 1'b0;
            tick       <= 1'b0;
            if (load) begin
                count <= load_sat;
            end else if (clear) begin
                count <= '0;
            end else if (step) begin
                count <= count_nxt;
                tick  <= 1'b1;
                carry <= wrap;
            end
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench for tick_bcd_counter: directed scenarios followed by
// random stimulus, all compared against an integer-arithmetic model.
module tb_tick_bcd_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  div_clk;
    logic [1:0]  rate_sel;
    logic        start, stop, up_dn, load, clear;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        carry, tick, running;

    int checks   = 0;
    int failures = 0;

    // model state
    int   m_count;
    bit   m_run, m_carry, m_tick, m_prev_src;
    int   m_prev_sel;

    always #5 clk = ~clk;

    tick_bcd_counter #(.NUM_DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_clk  (div_clk),
        .rate_sel (rate_sel),
        .start    (start),
        .stop     (stop),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .clear    (clear),
        .count    (count),
        .carry    (carry),
        .tick     (tick),
        .running  (running)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_to_int(input logic [15:0] lv);
        int v, d, w;
        v = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clk edge using the currently driven inputs,
    // then compare the DUT after the edge.
    task automatic cyc(input int n = 1);
        bit src, raw, stepping, wrapped;
        for (int k = 0; k < n; k++) begin
            if (rst) begin
                m_count = 0; m_run = 0; m_carry = 0; m_tick = 0;
                m_prev_src = 0; m_prev_sel = 0;
            end else begin
                src = (rate_sel == 2'd3) ? 1'b1 : div_clk[rate_sel];
                if (int'(rate_sel) != m_prev_sel) raw = 0;
                else if (rate_sel == 2'd3)         raw = 1;
                else                               raw = src && !m_prev_src;
                stepping = m_run && raw;
                m_carry = 0;
                m_tick  = 0;
                if (load) begin
                    m_count = load_to_int(load_val);
                end else if (clear) begin
                    m_count = 0;
                end else if (stepping) begin
                    if (up_dn) begin
                        wrapped = (m_count == 9999);
                        m_count = (m_count + 1) % 10000;
                    end else begin
                        wrapped = (m_count == 0);
                        m_count = (m_count + 9999) % 10000;
                    end
                    m_tick  = 1;
                    m_carry = wrapped;
                end
                if (stop)       m_run = 0;
                else if (start) m_run = 1;
                m_prev_src = src;
                m_prev_sel = int'(rate_sel);
            end
            @(posedge clk);
            #1;
            chk("count",   32'(count),   32'(to_bcd(m_count)));
            chk("carry",   32'(carry),   32'(m_carry));
            chk("tick",    32'(tick),    32'(m_tick));
            chk("running", 32'(running), 32'(m_run));
        end
    endtask

    initial begin
        rst = 1; div_clk = '0; rate_sel = 2'd3; start = 0; stop = 0;
        up_dn = 1; load = 0; load_val = '0; clear = 0;
        m_count = 0; m_run = 0; m_carry = 0; m_tick = 0; m_prev_src = 0; m_prev_sel = 0;
        @(negedge clk);

        // reset
        cyc(2);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_running", 32'(running), 32'h0);
        rst = 0;
        cyc(1);

        // every-cycle up count, 12 steps
        start = 1; cyc(1); start = 0;
        cyc(12);
        chk("clk_rate_12", 32'(count), 32'h0012);

        // divide-by-10 source: 5 rises in 50 cycles
        rate_sel = 2'd0; clear = 1; cyc(1); clear = 0;
        for (int i = 0; i < 50; i++) begin
            div_clk[0] = ((i / 5) % 2) == 1;
            cyc(1);
        end
        chk("div1_5steps", 32'(count), 32'h0005);

        // up wrap through 9999
        div_clk = '0; rate_sel = 2'd3; load = 1; load_val = 16'h9998; cyc(1); load = 0;
        cyc(1); chk("up_9999", 32'(count), 32'h9999);
        cyc(1); chk("up_0000", 32'(count), 32'h0000); chk("up_carry", 32'(carry), 32'h1);
        cyc(1); chk("up_0001", 32'(count), 32'h0001); chk("up_carry_clr", 32'(carry), 32'h0);

        // down wrap through 0000
        load = 1; load_val = 16'h0001; up_dn = 0; cyc(1); load = 0;
        cyc(1); chk("dn_0000", 32'(count), 32'h0000);
        cyc(1); chk("dn_9999", 32'(count), 32'h9999); chk("dn_carry", 32'(carry), 32'h1);
        cyc(1); chk("dn_9998", 32'(count), 32'h9998);

        // source switch while the new source is already high
        up_dn = 1; rate_sel = 2'd0; div_clk = 3'b000; cyc(2);
        div_clk = 3'b010; rate_sel = 2'd1; cyc(1);
        chk("switch_no_tick", 32'(tick), 32'h0);
        cyc(2);
        chk("switch_hold", 32'(count), 32'h9998);
        div_clk = 3'b000; cyc(2);
        div_clk = 3'b010; cyc(1);
        chk("switch_next_rise", 32'(count), 32'h9999);

        // start+stop together -> stop
        start = 1; stop = 1; cyc(1); start = 0; stop = 0;
        chk("stop_wins", 32'(running), 32'h0);
        for (int i = 0; i < 8; i++) begin
            div_clk[1] = i[0];
            cyc(1);
        end
        chk("stopped_hold", 32'(count), 32'h9999);
        load = 1; clear = 1; load_val = 16'h0042; cyc(1); load = 0; clear = 0;
        chk("load_over_clear", 32'(count), 32'h0042);
        load = 1; load_val = 16'hFA3C; cyc(1); load = 0;
        chk("load_saturate", 32'(count), 32'h9939);
        rst = 1; cyc(1); rst = 0;
        chk("rst_mid", 32'(count), 32'h0000);
        div_clk = 3'b000; rate_sel = 2'd0; cyc(2);
        div_clk = 3'b001; cyc(2);
        chk("rst_no_step", 32'(count), 32'h0000);

        // random phase
        start = 1; cyc(1); start = 0;
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom % 120) == 0;
            start    = ($urandom % 8) == 0;
            stop     = ($urandom % 20) == 0;
            load     = ($urandom % 25) == 0;
            clear    = ($urandom % 30) == 0;
            load_val = 16'($urandom);
            if (($urandom % 10) == 0) up_dn = ~up_dn;
            if (($urandom % 15) == 0) rate_sel = 2'($urandom);
            for (int b = 0; b < 3; b++)
                if (($urandom % 3) == 0) div_clk[b] = ~div_clk[b];
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
